// File: rtl/branch_predictor_pkg.sv
// bp_types: shared counter/BTB types and the saturating counter helper for branch_predictor
package bp_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    // tag is sized for the smallest BTB (upper bits stay zero for larger ones); target holds pc[31:2]
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic        is_jump;
    } btb_entry_t;

    function automatic bht_ctr_t sat_inc_dec(bht_ctr_t c, logic taken);
        return taken ? ((c == ST) ? ST : bht_ctr_t'(c + 2'd1))
                     : ((c == SNT) ? SNT : bht_ctr_t'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// bp_btb: direct-mapped tagged branch target buffer, combinational read, clock-edge write
module bp_btb
    import bp_types::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] rd_pc,
    output logic        rd_hit,
    output logic [29:0] rd_target,
    output logic        rd_is_jump,
    input  logic        wr_en,
    input  logic [31:2] wr_pc,
    input  logic [29:0] wr_target,
    input  logic        wr_is_jump
);

    localparam int ENTRIES = 1 << IDX_BITS;

    btb_entry_t          mem [ENTRIES];
    btb_entry_t          rd_e;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign rd_idx     = rd_pc[IDX_BITS+1:2];
    assign wr_idx     = wr_pc[IDX_BITS+1:2];
    assign rd_e       = mem[rd_idx];
    assign rd_hit     = rd_e.valid && (rd_e.tag == 30'(rd_pc[31:IDX_BITS+2]));
    assign rd_target  = rd_e.target;
    assign rd_is_jump = rd_e.is_jump;

    // Only valid bits are cleared on reset; a taken resolution overwrites the whole entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid: 1'b1, tag: 30'(wr_pc[31:IDX_BITS+2]),
                             target: wr_target, is_jump: wr_is_jump};
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit BHT + tagged BTB predictor with perf counters; BP_GSHARE_EN selects gshare indexing
module branch_predictor
    import bp_types::*;
#(
    parameter int BHT_IDX_BITS = 6,
    parameter int BTB_IDX_BITS = 4,
    parameter int GHR_BITS     = 6,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             pred_hit,
    input  logic             predict_en,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_br,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int BHT_N = 1 << BHT_IDX_BITS;

    bht_ctr_t                bht [BHT_N];
    bht_ctr_t                rd_ctr;
    logic [BHT_IDX_BITS-1:0] rd_idx;
    logic [BHT_IDX_BITS-1:0] wr_idx;
    logic                    upd;
    logic                    br_upd;
    logic                    mp_evt;
    logic                    btb_hit;
    logic                    btb_is_jump;
    logic [29:0]             btb_target;
    logic [31:0]             unused_ghr;
    logic [5:0]              unused_low;

    assign unused_ghr = GHR_BITS;
    assign unused_low = {if_pc[1:0], ex_pc[1:0], ex_target[1:0]};

    assign upd    = predict_en && ex_valid && (ex_is_br || ex_is_jump);
    assign br_upd = upd && ex_is_br;
    assign mp_evt = predict_en && ex_valid && ex_mispredict;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;
    logic [GHR_BITS-1:0] snap_id;
    logic [GHR_BITS-1:0] snap_ex;

    assign ghr_next = br_upd ? {ghr[GHR_BITS-2:0], ex_taken} : ghr;
    assign rd_idx   = if_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(ghr);
    assign wr_idx   = ex_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(snap_ex);

    // History follows resolved branches; snapshots track each fetch's history down to EX, resynced on mispredict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr     <= '0;
            snap_id <= '0;
            snap_ex <= '0;
        end else if (predict_en) begin
            ghr     <= ghr_next;
            snap_id <= mp_evt ? ghr_next : ghr;
            snap_ex <= mp_evt ? ghr_next : snap_id;
        end
    end
`else
    assign rd_idx = if_pc[BHT_IDX_BITS+1:2];
    assign wr_idx = ex_pc[BHT_IDX_BITS+1:2];
`endif

    assign rd_ctr      = bht[rd_idx];
    assign pred_hit    = btb_hit;
    assign pred_taken  = btb_hit && (rd_ctr >= WT || btb_is_jump);
    assign pred_target = btb_hit ? {btb_target, 2'b00} : {if_pc[31:2] + 30'd1, 2'b00};

    bp_btb #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_pc      (if_pc[31:2]),
        .rd_hit     (btb_hit),
        .rd_target  (btb_target),
        .rd_is_jump (btb_is_jump),
        .wr_en      (upd && ex_taken),
        .wr_pc      (ex_pc[31:2]),
        .wr_target  (ex_target[31:2]),
        .wr_is_jump (ex_is_jump)
    );

    // Train the direction counter of each resolved conditional branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= WNT;
        end else if (br_upd) begin
            bht[wr_idx] <= sat_inc_dec(bht[wr_idx], ex_taken);
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count         <= '0;
            mispredict_count <= '0;
        end else begin
            if (upd && br_count != '1) br_count <= br_count + CNT_W'(1);
            if (mp_evt && mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule
